aes_inv_round_iter: RTL
=======================

Name: aes_inv_round_iter

Overview:
- Iterative AES-128 decryption core: the inverse counterpart of the forward round datapath (subbytes/shiftrows/mixcolumns/addRoundKey).
- Executes one inverse round per clock over 10 rounds, with valid/ready handshakes on input and output.
- Round keys come from an external pre-expanded key store through a combinational address/data port.
- Sits between the ciphertext source and the plaintext consumer.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ciphertext offered
- in_ready  output  1  core can accept ciphertext
- ciphertext  input  128  block to decrypt; [127:120] is byte 0 (row 0, col 0), column-major per FIPS-197
- rk_addr  output  4  round-key index requested (0..10)
- rk_data  input  128  round key for rk_addr; must be valid combinationally in the same cycle
- out_valid  output  1  plaintext valid
- out_ready  input  1  consumer accepts plaintext
- plaintext  output  128  decrypted block, same byte order
- busy  output  1  high in ROUND and DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state register, plaintext = 0
  - round counter = 0
  - out_valid = 0, busy = 0
  - in_ready = 1 once reset deasserts
  - FSM = IDLE
- Reset asserted mid-operation aborts the block and discards any partial result.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1, rk_addr = 10.
  - On in_valid & in_ready, register state <= ciphertext ^ rk_data (rk10), set counter = 9, go to ROUND.
- ROUND:
  - in_ready = 0, rk_addr = counter.
  - For counter 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data); counter decrements.
  - For counter 0 (final round): plaintext <= InvSubBytes(InvShiftRows(state)) ^ rk_data, with no InvMixColumns; go to DONE.
- DONE:
  - out_valid = 1; plaintext is held stable until accepted.
  - On out_ready, out_valid drops at the next edge and the FSM goes to IDLE.
  - in_ready rises only in IDLE. There is no same-cycle accept while leaving DONE.
- Latency:
  - Call the accept edge E0. Rounds occupy edges E1..E10, and out_valid is high from just after E10.
  - If out_ready is already high, out_valid stays high for exactly one cycle.
  - Throughput with out_ready held high: one block per 12 cycles.
- in_valid while busy is ignored; ciphertext is sampled only at the accept edge.
- InvShiftRows: row r rotates right by r byte positions.
- InvMixColumns: matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11b.
- InvSubBytes: 16 parallel inverse S-box lookups (FIPS-197 Fig. 14), combinational, inside this block.
- rk_addr changes only on clock edges plus the FSM-state decode. The key store must not depend on out_ready.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; key store = expansion of 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5).
  - Required: plaintext 00112233445566778899aabbccddeeff.
  - Required: out_valid rises exactly 10 cycles after the E0 accept edge.
- FIPS-197 Appendix B:
  - Stimulus: ciphertext 3925841d02dc09fbdc118597196a0b32; key 2b7e151628aed2a6abf7158809cf4f3c (rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6).
  - Required: plaintext 3243f6a8885a308d313198a2e0370734.
- rk_addr sequence: record from accept through done -> required sequence 10 (IDLE), 9, 8, ..., 0, in single-cycle steps.
- Output backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles after out_valid rises, and pulse in_valid with a new block during DONE.
  - Required: plaintext stable, in_ready = 0, the new block is not accepted.
  - Required: after out_ready, in_ready = 1 the following cycle.
- Back-to-back:
  - Stimulus: two C.1 blocks with in_valid and out_ready held high.
  - Required: two identical plaintexts, second accept 12 cycles after the first.
- Reset mid-round:
  - Stimulus: assert rst at round counter 5, then release.
  - Required: out_valid = 0, plaintext = 0, in_ready = 1.
  - Required: a fresh C.1 decrypt afterwards gives the correct result.

Source files
------------

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, with round keys
// fetched from an external pre-expanded key store through rk_addr/rk_data.
module aes_inv_round_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    // IDLE: await ciphertext | ROUND: one inverse round per clk | DONE: hold plaintext
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [3:0] LAST_RK = 4'(NR);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    fsm_t         fsm_q;
    logic [127:0] state_q;
    logic [127:0] plaintext_q;
    logic [3:0]   cnt_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [15:0][7:0] st_b;
    logic [15:0][7:0] sr_b;
    logic [15:0][7:0] sb_b;
    logic [15:0][7:0] ark_b;
    logic [15:0][7:0] mc_b;
    logic [127:0]     state_d;
    logic [127:0]     plaintext_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant whose bits select b, 2b, 4b, 8b.
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    endfunction

    // Byte k (row k%4, col k/4) lives at packed index 15-k.
    assign st_b = state_q;

    for (genvar gc = 0; gc < 4; gc++) begin : g_isr_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_isr_row
            assign sr_b[15-(4*gc+gr)] = st_b[15-(4*((gc-gr+4)%4)+gr)];
        end
    end

    for (genvar gk = 0; gk < 16; gk++) begin : g_isb
        assign sb_b[gk] = INV_SBOX[{~sr_b[gk], 3'b000} +: 8];
    end

    assign ark_b = sb_b ^ rk_data;

    for (genvar gc = 0; gc < 4; gc++) begin : g_imc
        assign {mc_b[15-4*gc], mc_b[14-4*gc], mc_b[13-4*gc], mc_b[12-4*gc]} =
            inv_mix_col({ark_b[15-4*gc], ark_b[14-4*gc], ark_b[13-4*gc], ark_b[12-4*gc]});
    end

    assign state_d     = mc_b;
    assign plaintext_d = ark_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            plaintext_q <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= ciphertext ^ rk_data;
                        cnt_q      <= LAST_RK - 4'd1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        fsm_q      <= ROUND;
                    end
                end
                ROUND: begin
                    if (cnt_q == 4'd0) begin
                        plaintext_q <= plaintext_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        state_q <= state_d;
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign rk_addr   = (fsm_q == IDLE) ? LAST_RK : cnt_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign plaintext = plaintext_q;

endmodule
